// File: rtl/adder_reservation_station.sv
// Reservation station in front of the adder: buffers dispatched adds, snoops the CDB
// for pending operands, and issues one ready op at a time, waiting for completion.
module adder_reservation_station #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         dispatch_valid,
    output logic                         dispatch_ready,
    input  logic [TAG_W-1:0]             dispatch_tag,
    input  logic [4:0]                   dispatch_rd,
    input  logic [31:0]                  dispatch_vj,
    input  logic [31:0]                  dispatch_vk,
    input  logic                         dispatch_qj_pend,
    input  logic                         dispatch_qk_pend,
    input  logic [TAG_W-1:0]             dispatch_qj,
    input  logic [TAG_W-1:0]             dispatch_qk,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [31:0]                  cdb_value,
    input  logic                         fu_busy,
    input  logic                         fu_complete,
    output logic                         issue_start,
    output logic [4:0]                   issue_rd,
    output logic [TAG_W-1:0]             issue_tag,
    output logic [31:0]                  issue_operand_a,
    output logic [31:0]                  issue_operand_b,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [4:0]       rd;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic             qj_pend;
        logic [TAG_W-1:0] qj;
        logic             qk_pend;
        logic [TAG_W-1:0] qk;
    } entry_t;

    typedef enum logic {IDLE, WAIT} state_t;

    entry_t             entries [DEPTH];
    entry_t             new_entry;
    state_t             state, next_state;
    logic               fu_complete_q;
    logic               any_ready;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   free_idx;
    logic               accept;
    logic               do_issue;

    assign dispatch_ready = (occupancy != OCC_W'(DEPTH));
    assign accept         = dispatch_valid && dispatch_ready;

    // Descending scan so the lowest index wins for both select and allocation.
    always_comb begin
        any_ready = 1'b0;
        sel_idx   = '0;
        free_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (entries[i].valid && !entries[i].qj_pend && !entries[i].qk_pend) begin
                sel_idx   = IDX_W'(i);
                any_ready = 1'b1;
            end
            if (!entries[i].valid)
                free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        new_entry.valid   = 1'b1;
        new_entry.tag     = dispatch_tag;
        new_entry.rd      = dispatch_rd;
        new_entry.vj      = dispatch_vj;
        new_entry.vk      = dispatch_vk;
        new_entry.qj_pend = dispatch_qj_pend;
        new_entry.qj      = dispatch_qj;
        new_entry.qk_pend = dispatch_qk_pend;
        new_entry.qk      = dispatch_qk;
        if (cdb_valid && dispatch_qj_pend && dispatch_qj == cdb_tag) begin
            new_entry.vj      = cdb_value;
            new_entry.qj_pend = 1'b0;
        end
        if (cdb_valid && dispatch_qk_pend && dispatch_qk == cdb_tag) begin
            new_entry.vk      = cdb_value;
            new_entry.qk_pend = 1'b0;
        end
    end

    always_comb begin
        next_state = state;
        do_issue   = 1'b0;
        case (state)
            IDLE: if (any_ready && !fu_busy) begin
                do_issue   = 1'b1;
                next_state = WAIT;
            end
            WAIT: if (fu_complete && !fu_complete_q)
                next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            fu_complete_q <= 1'b0;
        end else begin
            state         <= next_state;
            fu_complete_q <= fu_complete;
        end
    end

    // Allocation only targets invalid slots and issue only valid ones, so a slot
    // freed by issue this cycle cannot be reallocated until the next.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                entries[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries[i].valid) begin
                    if (cdb_valid && entries[i].qj_pend && entries[i].qj == cdb_tag) begin
                        entries[i].vj      <= cdb_value;
                        entries[i].qj_pend <= 1'b0;
                    end
                    if (cdb_valid && entries[i].qk_pend && entries[i].qk == cdb_tag) begin
                        entries[i].vk      <= cdb_value;
                        entries[i].qk_pend <= 1'b0;
                    end
                    if (do_issue && sel_idx == IDX_W'(i))
                        entries[i].valid <= 1'b0;
                end else if (accept && free_idx == IDX_W'(i)) begin
                    entries[i] <= new_entry;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            issue_start     <= 1'b0;
            issue_rd        <= '0;
            issue_tag       <= '0;
            issue_operand_a <= '0;
            issue_operand_b <= '0;
            occupancy       <= '0;
        end else begin
            issue_start <= do_issue;
            if (do_issue) begin
                issue_rd        <= entries[sel_idx].rd;
                issue_tag       <= entries[sel_idx].tag;
                issue_operand_a <= entries[sel_idx].vj;
                issue_operand_b <= entries[sel_idx].vk;
            end
            occupancy <= occupancy + OCC_W'(accept) - OCC_W'(do_issue);
        end
    end

endmodule

// File: doc/adder_reservation_station.md
# adder_reservation_station

Reservation station that sits directly upstream of the adder functional unit in the out-of-order core. It buffers up to DEPTH dispatched add instructions and snoops the common data bus (CDB) for pending source operands. It issues one ready instruction at a time to the adder, then waits for that operation to complete before issuing the next. It provides the dispatch back-pressure (full) signal to the decode/dispatch stage.

## Interface
- DEPTH, 4, number of entries (2..8)
- TAG_W, 4, width of rename/ROB tags
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- dispatch_valid  input  1  dispatch stage presents an instruction
- dispatch_ready  output  1  a free entry exists (not full)
- dispatch_tag  input  TAG_W  tag of the instruction's result
- dispatch_rd  input  5  architectural destination register
- dispatch_vj, dispatch_vk  input  32  operand values (used when not pending)
- dispatch_qj_pend, dispatch_qk_pend  input  1  operand awaits a CDB broadcast
- dispatch_qj, dispatch_qk  input  TAG_W  producer tag of a pending operand
- cdb_valid  input  1  CDB broadcast this cycle
- cdb_tag  input  TAG_W  broadcast tag
- cdb_value  input  32  broadcast value
- fu_busy  input  1  adder busy
- fu_complete  input  1  adder completion flag (level, may stay high several cycles)
- issue_start  output  1  one-cycle start pulse to adder
- issue_rd  output  5  destination register for the issued op
- issue_tag  output  TAG_W  tag for the issued op
- issue_operand_a, issue_operand_b  output  32  operands (vj, vk)
- occupancy  output  $clog2(DEPTH+1)  number of valid entries

## Operation
- Entry fields: valid, tag, rd, vj, vk, qj_pend, qj, qk_pend, qk.
- Dispatch: accepted when dispatch_valid && dispatch_ready; written into the lowest-index free entry. dispatch_ready = (occupancy != DEPTH), computed from registered state only.
- Dispatch bypass: if cdb_valid and cdb_tag matches a pending dispatch_qj/qk in the same cycle, the operand is stored as cdb_value and its pend bit is cleared.
- Wakeup: each cycle, every valid entry with qj_pend (qk_pend) and qj == cdb_tag under cdb_valid captures cdb_value into vj (vk) and clears the pend bit. Both operands may wake in the same cycle.
- Ready entry: valid && !qj_pend && !qk_pend, evaluated on registered state. An entry woken this cycle is not issuable until the next cycle.
- Select: lowest-index ready entry.
- FSM states:
  - IDLE: if any entry is ready and !fu_busy, register the selected entry onto the issue_* outputs, pulse issue_start, clear the entry's valid bit, and go to WAIT.
  - WAIT: stay until a rising edge of fu_complete (fu_complete=1 while its registered copy was 0), then go to IDLE. A stale high fu_complete on entry to WAIT does not count.
- Simultaneous dispatch and issue: the slot freed by the issue is not reusable until the next cycle. occupancy decrements and increments in the same cycle, so the net change is 0.
- Arithmetic: none. Values pass through unmodified. occupancy never exceeds DEPTH or goes below 0.
- Reset (reset=0): all entries invalid, state IDLE, occupancy=0, issue_start=0, issue_rd=0, issue_tag=0, issue_operand_a/b=0, dispatch_ready=1 from the next cycle. Reset mid-WAIT discards all in-flight bookkeeping.

## Timing
- All outputs are registered except dispatch_ready, which is combinational from registered occupancy.
- Dispatch accepted at edge N with both operands ready, state IDLE, fu_busy=0: issue_start=1 during cycle N+1.
- issue_start is high for exactly one cycle. issue_rd, issue_tag and issue_operand_* hold their values until the next issue.
- Earliest back-to-back issue: one cycle after the fu_complete rising edge is sampled.
- A CDB wakeup at edge N makes the entry issuable at edge N+1.
- Full: while occupancy==DEPTH, dispatch_ready=0 and dispatch_valid is ignored. dispatch_ready returns to 1 the cycle after an issue.

## Test plan
- Reset then dispatch (tag=3, rd=5, vj=10, vk=20, none pending): issue_start pulses one cycle later with issue_rd=5, issue_tag=3, operands 10/20. occupancy goes 1 then 0.
- Dispatch with qj pending on tag 7, then cdb_valid with tag=7, value=0xFFFF_FFFF two cycles later: no issue before the broadcast. Issue occurs one cycle after it with issue_operand_a=0xFFFF_FFFF.
- Dispatch with qk pending on tag 2 while cdb_valid, tag=2, value=99 in the same cycle: operand is captured via bypass. Issue follows next cycle with issue_operand_b=99.
- Fill DEPTH=4 entries with ready ops while fu_busy=1: dispatch_ready=0 and a fifth dispatch is ignored. Release fu_busy: entries issue in index order 0..3, each only after a fresh fu_complete rising edge.
- Hold fu_complete high continuously across an issue: the block stays in WAIT until fu_complete drops and rises again. No second issue_start occurs meanwhile.
- Assert reset=0 while in WAIT with 3 entries valid: next cycle occupancy=0, dispatch_ready=1, no issue_start until new dispatches arrive.
